// File: rtl/seq_shift_pkg.sv
// Shared definitions for the sequential rotate/shift-left block.
// Holds the default word geometry, the operation encodings and the FSM
// state encoding used by seq_rotl_shifter.
package seq_shift_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int AMT_W_DEF = 3;

  // Operation select carried on in_op.
  localparam logic OP_SLL = 1'b0;  // logical shift left, zero fill
  localparam logic OP_ROL = 1'b1;  // rotate left

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_rotl_shifter_shl1_stage.sv
// shl1_stage: combinational single-bit left step.
// Ports:
//   data   - word before the step
//   op     - OP_SLL fills the LSB with 0, OP_ROL fills it with the old MSB
//   result - word after the step
module shl1_stage
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  logic             op,
  output logic [WIDTH-1:0] result
);

  logic fill;

  assign fill   = (op == OP_ROL) ? data[WIDTH-1] : 1'b0;
  assign result = {data[WIDTH-2:0], fill};

endmodule

// File: rtl/seq_rotl_shifter.sv
// seq_rotl_shifter: shifts or rotates a word left by in_amt positions, one
// bit per clock, using a single shl1_stage.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request; in_ready=1
//   SHIFT  | one left step per edge; counter counts down to 0
//   DONE   | result held on out_data with out_valid=1 until out_ready
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - request handshake (in_data, in_amt, in_op)
//   out_valid/out_ready  - result handshake (out_data)
//   busy                 - high whenever not IDLE
module seq_rotl_shifter
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic             op_q, op_nxt;
  logic [WIDTH-1:0] step_out;

  shl1_stage #(.WIDTH(WIDTH)) u_step (
    .data   (work),
    .op     (op_q),
    .result (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      work  <= '0;
      cnt   <= '0;
      op_q  <= OP_SLL;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          work_nxt  = in_data;
          cnt_nxt   = in_amt;
          op_nxt    = in_op;
          // A zero amount skips SHIFT so the result appears one edge later.
          state_nxt = (in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_nxt = step_out;
        cnt_nxt  = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE here never accepts in the same edge, which
        // guarantees an IDLE cycle between consecutive results.
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_data = work;

endmodule
